// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the
// instruction-fetch and load/store requesters, one transaction at a time.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_funct3,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate between pending requests
  // ISSUE | mem_req held with stable fields until mem_gnt
  // WAIT  | accepted by memory; waiting for mem_rvalid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_funct3_q, mem_funct3_d;
  logic          pick;
  logic          complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_F;
      last_q       <= OWN_F;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    pick         = OWN_F;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On a tie the requester that did not own the last transaction wins.
          pick      = (if_req && d_req) ? ~last_q : d_req;
          owner_d   = pick;
          last_d    = pick;
          mem_req_d = 1'b1;
          state_d   = ISSUE;
          if (pick == OWN_D) begin
            d_gnt_d      = 1'b1;
            mem_we_d     = d_we;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            mem_funct3_d = d_funct3;
          end else begin
            if_gnt_d     = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr;
            mem_wdata_d  = '0;
            mem_funct3_d = 3'b010;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_rvalid) complete = 1'b1;
          else            state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d = IDLE;
      if (owner_q == OWN_D) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_rdata;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata;
      end
    end
  end

  assign if_gnt     = if_gnt_q;
  assign d_gnt      = d_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, tie-break, round-robin,
// same-cycle gnt/rvalid, stall hold and reset while a transaction is in WAIT.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_funct3 = 3'b000;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_gnts", {if_gnt, d_gnt}, 0);
    rst_n = 1'b1;
    step();

    // single fetch
    if_req = 1; if_addr = 32'h100;
    step();
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_funct3", mem_funct3, 3'b010);
    chk("f_mem_we", mem_we, 0);
    chk("f_busy", busy, 1);
    if_req = 0;
    step();
    chk("f_gnt_pulse", if_gnt, 0);
    mem_gnt = 1;
    step();
    chk("f_mem_req_low", mem_req, 0);
    mem_gnt = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    step();
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_d_rvalid", d_rvalid, 0);
    chk("f_busy_done", busy, 0);
    mem_rvalid = 0;
    step();
    chk("f_rvalid_pulse", if_rvalid, 0);

    // tie after reset: data wins
    do_reset();
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_addr = 32'h200; d_we = 1; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    step();
    chk("t_d_gnt", d_gnt, 1);
    chk("t_if_gnt", if_gnt, 0);
    chk("t_mem_we", mem_we, 1);
    chk("t_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t_mem_addr", mem_addr, 32'h200);
    d_req = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    step();
    chk("t_d_rvalid", d_rvalid, 1);
    chk("t_if_gnt_early", if_gnt, 0);
    mem_rvalid = 0;
    step();
    chk("t_if_gnt_next", if_gnt, 1);
    chk("t_f_addr", mem_addr, 32'h300);
    chk("t_f_we", mem_we, 0);
    chk("t_f_wdata", mem_wdata, 0);
    if_req = 0;

    // same-cycle gnt and rvalid in the first ISSUE cycle
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h12;
    step();
    chk("s_if_rvalid", if_rvalid, 1);
    chk("s_if_rdata", if_rdata, 32'h12);
    chk("s_busy", busy, 0);
    chk("s_mem_req", mem_req, 0);
    mem_gnt = 0; mem_rvalid = 0;
    step();
    chk("s_rvalid_pulse", if_rvalid, 0);
    chk("s_rdata_hold", if_rdata, 32'h12);

    // sustained contention: last owner is fetch, so D,F,D,F,D,F
    if_req = 1; if_addr = 32'h600; d_req = 1; d_addr = 32'h700; d_we = 0;
    for (int i = 0; i < 6; i++) begin
      seen = 0;
      for (int w = 0; w < 8; w++) begin
        if (if_gnt || d_gnt) begin seen = 1; break; end
        step();
      end
      chk($sformatf("rr_seen%0d", i), seen, 1);
      chk($sformatf("rr_d_gnt%0d", i), d_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_if_gnt%0d", i), if_gnt, (i % 2 == 0) ? 0 : 1);
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1000 + i;
      step();
      chk($sformatf("rr_d_rv%0d", i), d_rvalid, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_if_rv%0d", i), if_rvalid, (i % 2 == 0) ? 0 : 1);
      mem_gnt = 0; mem_rvalid = 0;
    end
    if_req = 0; d_req = 0;
    step();

    // stall hold with a competing fetch and a stray rvalid in ISSUE
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h55AA; d_funct3 = 3'b001;
    step();
    chk("h_d_gnt", d_gnt, 1);
    d_req = 0; d_wdata = 32'h0; d_addr = 32'h0;
    if_req = 1; if_addr = 32'h500;
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = (c == 2);
      step();
      chk($sformatf("h_req%0d", c), mem_req, 1);
      chk($sformatf("h_addr%0d", c), mem_addr, 32'h400);
      chk($sformatf("h_wdata%0d", c), mem_wdata, 32'h55AA);
      chk($sformatf("h_if_gnt%0d", c), if_gnt, 0);
      chk($sformatf("h_d_rv%0d", c), d_rvalid, 0);
    end
    mem_rvalid = 0; mem_gnt = 1;
    step();
    chk("h_req_low", mem_req, 0);
    chk("h_if_gnt_w", if_gnt, 0);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    step();
    chk("h_d_rvalid", d_rvalid, 1);
    chk("h_d_rdata", d_rdata, 32'hCAFE);
    chk("h_if_gnt_rv", if_gnt, 0);
    mem_rvalid = 0;
    step();
    chk("h_if_gnt", if_gnt, 1);
    chk("h_f_addr", mem_addr, 32'h500);
    if_req = 0;

    // reset while in WAIT
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("r_busy_wait", busy, 1);
    rst_n = 0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_mem_req", mem_req, 0);
    chk("r_mem_addr", mem_addr, 0);
    chk("r_mem_wdata", mem_wdata, 0);
    chk("r_mem_funct3", mem_funct3, 0);
    chk("r_if_rdata", if_rdata, 0);
    chk("r_d_rdata", d_rdata, 0);
    chk("r_pulses", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}, 0);
    step();
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    step();
    mem_rvalid = 0;
    chk("r_stray_rv", {if_rvalid, d_rvalid}, 0);
    chk("r_stray_busy", busy, 0);
    step();
    chk("r_stray_rdata", if_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
